seg7_scan_ctrl: RTL

//  Time-multiplexes one 4-bit-to-7-segment decoder across NUM_DIGITS digits.
//  - Drives the shared decoder's nibble inputs (x_3..x_0 = nibble_out[3:0])
//    and one-hot digit anodes.
//  - Holds a frame buffer loaded through a valid/ready handshake.
//  - Buffer updates apply only at frame boundaries, so no digit shows mixed data.

---
 rtl/seg7_scan_ctrl_pkg.sv | 25 ++
 rtl/seg7_scan_ctrl_if.sv | 35 +++
 rtl/seg7_tick_gen.sv | 29 ++
 rtl/seg7_scan_ctrl.sv | 133 +++++++++++++
 4 files changed

// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan controller.
package seg7_pkg;

    // Scan phases: all anodes dark (GUARD) or one digit lit (DRIVE).
    typedef enum logic {
        S_GUARD = 1'b0,
        S_DRIVE = 1'b1
    } scan_state_t;

    // Widest display the controller is sized for.
    localparam int MAX_DIGITS = 8;

    // Inactive anode vector for an n-digit display, zero-extended to MAX_DIGITS.
    function automatic logic [MAX_DIGITS-1:0] an_inactive(input int n, input bit active_low);
        logic [MAX_DIGITS-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if ((i < n) && active_low) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Signal bundle between the frame producer / display and the scan controller.
interface seg7_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    import seg7_pkg::*;

    localparam int IDX_W = $clog2(NUM_DIGITS);

    // Frame write handshake: a frame is transferred on every clock edge where
    // load (valid) and ready are both 1. data_in is only meaningful while load
    // is 1. ready drops the cycle after a transfer and stays 0 until that frame
    // has been committed to the display; load while ready = 0 is dropped, not
    // queued, and the producer may deassert load at any time.
    logic                    en;
    logic                    load;
    logic                    ready;
    logic [4*NUM_DIGITS-1:0] data_in;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic [3:0]              nibble_out;
    logic [NUM_DIGITS-1:0]   an;
    logic [IDX_W-1:0]        digit_idx;
    logic                    frame_tick;
    scan_state_t             dbg_state;

    modport master (
        output en, load, data_in, blank_mask,
        input  ready, nibble_out, an, digit_idx, frame_tick, dbg_state
    );

    modport slave (
        input  en, load, data_in, blank_mask,
        output ready, nibble_out, an, digit_idx, frame_tick, dbg_state
    );

endinterface

// File: rtl/seg7_tick_gen.sv
// Loadable down-counter timing both the guard and the drive intervals.
// A start pulse loads len-1; done is high during the last cycle of the interval.
module seg7_tick_gen #(
    parameter int               CNT_W   = 4,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    output logic             done
);

    logic [CNT_W-1:0] r_cnt;

    // Load on start, otherwise count down and park at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= RST_VAL;
        end else if (start) begin
            r_cnt <= len - 1'b1;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign done = (r_cnt == '0);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexes one shared 4-bit-to-7-segment decoder across NUM_DIGITS
// digits, with a double-buffered frame that only changes at frame boundaries.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_DIV   = 50000,
    parameter int GUARD_CYC     = 16,
    parameter int ACTIVE_LOW_AN = 1
) (
    input  logic            clk,
    input  logic            reset,
    seg7_scan_ctrl_if.slave bus
);

    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int CNT_MAX = (REFRESH_DIV > GUARD_CYC) ? REFRESH_DIV : GUARD_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]      GUARD_LEN  = CNT_W'(GUARD_CYC);
    localparam logic [CNT_W-1:0]      DRIVE_LEN  = CNT_W'(REFRESH_DIV);
    localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [MAX_DIGITS-1:0] AN_OFF_ALL = an_inactive(NUM_DIGITS, ACTIVE_LOW_AN != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF     = AN_OFF_ALL[NUM_DIGITS-1:0];

    scan_state_t             r_state;
    logic [IDX_W-1:0]        r_digit_idx;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [4*NUM_DIGITS-1:0] r_pending_buf;
    logic                    r_pending;
    logic                    r_ready;
    logic                    r_frame_tick;
    logic [3:0]              r_nibble;
    logic [NUM_DIGITS-1:0]   r_an;

    logic                    w_done;
    logic                    w_start;
    logic [CNT_W-1:0]        w_len;
    scan_state_t             w_state_nxt;
    logic [IDX_W-1:0]        w_idx_nxt;
    logic                    w_wrap;
    logic                    w_commit;
    logic [4*NUM_DIGITS-1:0] w_shadow_nxt;
    logic [NUM_DIGITS-1:0]   w_sel;
    logic                    w_lit;

    // The guard counter comes out of reset preloaded, so the very first guard
    // interval is as long as every later one.
    seg7_tick_gen #(
        .CNT_W   (CNT_W),
        .RST_VAL (GUARD_LEN - 1'b1)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .start (w_start),
        .len   (w_len),
        .done  (w_done)
    );

    // Next scan position, interval restarts and frame commit decision.
    // While disabled the counter is kept reloaded with a guard interval, so
    // re-enabling always begins with a full guard on the held digit.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_digit_idx;
        w_wrap      = 1'b0;
        w_start     = 1'b0;
        w_len       = GUARD_LEN;
        if (!bus.en) begin
            w_state_nxt = S_GUARD;
            w_start     = 1'b1;
        end else if (w_done) begin
            w_start = 1'b1;
            if (r_state == S_GUARD) begin
                w_state_nxt = S_DRIVE;
                w_len       = DRIVE_LEN;
            end else begin
                w_state_nxt = S_GUARD;
                if (r_digit_idx == LAST_IDX) begin
                    w_idx_nxt = '0;
                    w_wrap    = 1'b1;
                end else begin
                    w_idx_nxt = r_digit_idx + 1'b1;
                end
            end
        end
        // A dark display (en = 0) cannot tear, so a waiting frame goes in at once.
        w_commit     = r_pending & (w_wrap | ~bus.en);
        w_shadow_nxt = w_commit ? r_pending_buf : r_shadow;
        w_sel        = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << w_idx_nxt;
        w_lit        = (w_state_nxt == S_DRIVE) && !bus.blank_mask[w_idx_nxt];
    end

    // Scan FSM, frame buffers, handshake and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_GUARD;
            r_digit_idx   <= '0;
            r_shadow      <= '0;
            r_pending_buf <= '0;
            r_pending     <= 1'b0;
            r_ready       <= 1'b1;
            r_frame_tick  <= 1'b0;
            r_nibble      <= 4'h0;
            r_an          <= AN_OFF;
        end else begin
            r_state      <= w_state_nxt;
            r_digit_idx  <= w_idx_nxt;
            r_shadow     <= w_shadow_nxt;
            r_frame_tick <= w_wrap;
            // The decoder input follows the next digit even in guard, so it
            // has settled before the anode turns on.
            r_nibble     <= w_shadow_nxt[{w_idx_nxt, 2'b00} +: 4];
            r_an         <= w_lit ? (AN_OFF ^ w_sel) : AN_OFF;
            if (w_commit) begin
                r_pending <= 1'b0;
                r_ready   <= 1'b1;
            end else if (bus.load && r_ready) begin
                r_pending_buf <= bus.data_in;
                r_pending     <= 1'b1;
                r_ready       <= 1'b0;
            end
        end
    end

    assign bus.ready      = r_ready;
    assign bus.nibble_out = r_nibble;
    assign bus.an         = r_an;
    assign bus.digit_idx  = r_digit_idx;
    assign bus.frame_tick = r_frame_tick;
    assign bus.dbg_state  = r_state;

endmodule
